// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and encodings for the clock-enable divider controller.
// Imported by the top level and by the down-counter.
package clk_div_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int CNT_W_DEF  = 16;
    localparam int TCNT_W_DEF = 8;

endpackage

// File: rtl/clk_div_ctrl_counter.sv
// Loadable down-counter that paces the tick enable.
// A load takes priority over a decrement; zero is a plain combinational decode.
module div_down_counter
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: one tick every cfg_div+1 cycles on clk,
// plus a square wave toggling on each tick. No derived clocks.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | stopped; cfg accepted; start (without stop) loads the counter
// ST_RUN  | counting down; tick on terminal count; stop returns to IDLE
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TCNT_W = TCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic              start,
    input  logic              stop,
    output logic              tick,
    output logic              sq_out,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_cnt
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic                mode_q, mode_d;
    logic                tick_q, tick_d;
    logic                sq_q, sq_d;
    logic                busy_q, busy_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;

    logic                cfg_accept;
    logic [CNT_W-1:0]    eff_div;
    logic                eff_mode;
    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_load_val;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_value;
    logic                cnt_zero;

    div_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    // A cfg accepted on the same edge as start is used immediately (bypass).
    assign cfg_accept = cfg_valid && (state_q == ST_IDLE);
    assign eff_div    = cfg_accept ? cfg_div  : div_q;
    assign eff_mode   = cfg_accept ? cfg_mode : mode_q;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        mode_d       = mode_q;
        tick_d       = 1'b0;
        sq_d         = sq_q;
        tick_cnt_d   = tick_cnt_q;
        cnt_load     = 1'b0;
        cnt_load_val = div_q;
        cnt_en       = 1'b0;

        if (cfg_accept) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d      = ST_RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = eff_div;
                    tick_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    tick_d       = 1'b1;
                    sq_d         = ~sq_q;
                    tick_cnt_d   = tick_cnt_q + TCNT_W'(1);
                    cnt_load     = 1'b1;
                    cnt_load_val = div_q;
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d == ST_RUN);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            mode_q      <= MODE_PERIODIC;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign tick      = tick_q;
    assign sq_out    = sq_q;
    assign tick_cnt  = tick_cnt_q;

endmodule
